alu_status_unit: RTL and testbench
==================================

Name: alu_status_unit

Overview:
Consumer side of the ALU result/flag interface. It captures the ALU's flag outputs and result into an architectural status register (SR) and a result latch. It evaluates branch condition codes against the captured flags, with a registered taken/not-taken response. It also provides SR save/restore over the data path, and sits between the ALU and the fetch/branch logic of the CPU.

Parameters:
DATA_W, 8, width of ALU result and of the SR read/write data path (must be >= 4).

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
alu_func  input  alu_func_e  function the ALU executed this cycle (ADD, SUB, AND, OR, XOR, INV)
alu_result  input  DATA_W  ALU result bus
zero_flag  input  1  ALU Z
negative_flag  input  1  ALU N
carry_flag  input  1  ALU C (undefined for logic ops)
signed_overflow  input  1  ALU V (undefined for logic ops)
flags_update  input  1  commit this cycle's ALU flags/result
sr_write  input  1  load SR from sr_wdata
sr_wdata  input  DATA_W  SR restore value; bit0=Z bit1=N bit2=C bit3=V, upper bits ignored
branch_req  input  1  request condition evaluation
branch_cond  input  4  condition code
sr_rdata  output  DATA_W  {zeros, V, C, N, Z} from registered SR
result_q  output  DATA_W  last committed ALU result
branch_valid  output  1  one-cycle pulse, response to branch_req
branch_taken  output  1  condition outcome; valid only when branch_valid=1
illegal_cond  output  1  one-cycle pulse with branch_valid when branch_cond is unassigned

Behaviour:
- Reset (rst=1 at an edge): Z,N,C,V=0; result_q=0; branch_valid=0, branch_taken=0, illegal_cond=0. Any pending branch_req in that cycle is dropped. rst has priority over all other inputs.
- Flag commit (flags_update=1, sr_write=0):
  - Z and N always load from the ALU; result_q loads alu_result.
  - C and V load only when alu_func is ADD or SUB. For AND/OR/XOR/INV, C and V retain their prior value; their undefined ALU values must never enter state.
  - An alu_func outside the enum updates nothing. Simulation asserts this case.
- sr_write=1: Z,N,C,V load from sr_wdata[3:0]; result_q unchanged. If flags_update=1 in the same cycle, sr_write wins and the ALU flags are discarded. result_q still updates from alu_result.
- Branch evaluation:
  - branch_req at cycle n produces branch_valid=1 at cycle n+1, latency 1, no stall, one request per cycle, fully pipelined.
  - Evaluation uses the next-state flags, i.e. flags as committed by any flags_update/sr_write in cycle n (bypass). A compare followed in the same cycle by its branch sees the fresh flags.
- Condition codes (C is the borrow after SUB):
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 N
  - 4 !N
  - 5 C
  - 6 !C
  - 7 V
  - 8 !V
  - 9 signed lt: N^V
  - 10 signed ge: !(N^V)
  - 11 unsigned le: C|Z
  - 12 unsigned gt: !C & !Z
  - 13-15 illegal: branch_taken=0, illegal_cond=1.
- Without branch_req: branch_valid, branch_taken and illegal_cond are 0 next cycle; taken is forced 0 when not valid.
- sr_rdata and result_q are registered and reflect state after the last edge; no combinational path from inputs.
- Upper sr_rdata bits [DATA_W-1:4] are always 0.

Test Plan:
- Reset mid-sequence: commit ADD 0x7F+0x01 (V=1, N=1), then rst=1 with branch_req cond=7 in the same cycle -> next cycle sr_rdata=0x00, result_q=0x00, branch_valid=0.
- ADD 0xFF+0x01 with flags_update -> sr_rdata=0x05 (Z,C), result_q=0x00. Then XOR result 0x80 with flags_update -> sr_rdata=0x06 (N set, C retained, Z cleared).
- Bypass: SUB 0x03-0x05 (result 0xFE, C=1, N=1) with flags_update plus branch_req cond=11 in the same cycle -> next cycle branch_valid=1, branch_taken=1. Same cycle cond=12 -> branch_taken=0.
- Signed compare: SUB 0x80-0x01 (result 0x7F, V=1, N=0) then branch cond=9 -> taken=1. Then cond=10 -> taken=0.
- Priority: sr_write=1 with sr_wdata=0xA8 together with flags_update for ADD setting Z -> sr_rdata=0x08, result_q=alu_result.
- Back-to-back branch_req on cycles n..n+3 with conds 0, 2, 14, 1 and Z=1 -> valid on n+1..n+4, taken=1,0,0,1, illegal_cond=1 only on n+3.

Source files
------------

// File: rtl/alu_status_unit.sv
// ALU status unit: captures ALU flags/result into an architectural status
// register, supports SR save/restore, and evaluates branch conditions with a
// one-cycle registered response that sees the flags being committed this cycle.

package alu_status_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_INV = 3'd5
    } alu_func_e;
endpackage

module alu_status_unit
    import alu_status_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  alu_func_e         alu_func,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero_flag,
    input  logic              negative_flag,
    input  logic              carry_flag,
    input  logic              signed_overflow,
    input  logic              flags_update,
    input  logic              sr_write,
    input  logic [DATA_W-1:0] sr_wdata,
    input  logic              branch_req,
    input  logic [3:0]        branch_cond,
    output logic [DATA_W-1:0] sr_rdata,
    output logic [DATA_W-1:0] result_q,
    output logic              branch_valid,
    output logic              branch_taken,
    output logic              illegal_cond
);

    // Architectural state
    logic              r_z;
    logic              r_n;
    logic              r_c;
    logic              r_v;
    logic [DATA_W-1:0] r_result;
    logic              r_branch_valid;
    logic              r_branch_taken;
    logic              r_illegal_cond;

    // Next-state values (also used as the branch bypass)
    logic              w_z_next;
    logic              w_n_next;
    logic              w_c_next;
    logic              w_v_next;
    logic [DATA_W-1:0] w_result_next;

    logic              w_func_arith;
    logic              w_func_logic;
    logic              w_func_legal;
    logic              w_commit;
    logic              w_cond_true;
    logic              w_cond_illegal;
    logic [3:0]        w_sr_bits;

    // Decode the ALU function class; only ADD/SUB produce meaningful C and V
    always_comb begin
        w_func_arith = (alu_func == ALU_ADD) || (alu_func == ALU_SUB);
        w_func_logic = (alu_func == ALU_AND) || (alu_func == ALU_OR) ||
                       (alu_func == ALU_XOR) || (alu_func == ALU_INV);
        w_func_legal = w_func_arith || w_func_logic;
        w_commit     = flags_update && w_func_legal;
    end

    // Next-state flags and result: SR restore beats the ALU flag commit,
    // while the result latch still follows a valid commit
    always_comb begin
        w_z_next      = r_z;
        w_n_next      = r_n;
        w_c_next      = r_c;
        w_v_next      = r_v;
        w_result_next = r_result;
        if (sr_write) begin
            w_z_next = sr_wdata[0];
            w_n_next = sr_wdata[1];
            w_c_next = sr_wdata[2];
            w_v_next = sr_wdata[3];
        end else if (w_commit) begin
            w_z_next = zero_flag;
            w_n_next = negative_flag;
            if (w_func_arith) begin
                w_c_next = carry_flag;
                w_v_next = signed_overflow;
            end
        end
        if (w_commit) begin
            w_result_next = alu_result;
        end
    end

    // Condition evaluation against the bypassed (next-state) flags
    always_comb begin
        w_cond_true    = 1'b0;
        w_cond_illegal = 1'b0;
        case (branch_cond)
            4'd0:    w_cond_true = 1'b1;
            4'd1:    w_cond_true = w_z_next;
            4'd2:    w_cond_true = !w_z_next;
            4'd3:    w_cond_true = w_n_next;
            4'd4:    w_cond_true = !w_n_next;
            4'd5:    w_cond_true = w_c_next;
            4'd6:    w_cond_true = !w_c_next;
            4'd7:    w_cond_true = w_v_next;
            4'd8:    w_cond_true = !w_v_next;
            4'd9:    w_cond_true = w_n_next ^ w_v_next;
            4'd10:   w_cond_true = !(w_n_next ^ w_v_next);
            4'd11:   w_cond_true = w_c_next | w_z_next;
            4'd12:   w_cond_true = !w_c_next & !w_z_next;
            default: w_cond_illegal = 1'b1;
        endcase
    end

    // Status register, result latch and registered branch response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z            <= 1'b0;
            r_n            <= 1'b0;
            r_c            <= 1'b0;
            r_v            <= 1'b0;
            r_result       <= '0;
            r_branch_valid <= 1'b0;
            r_branch_taken <= 1'b0;
            r_illegal_cond <= 1'b0;
        end else begin
            r_z            <= w_z_next;
            r_n            <= w_n_next;
            r_c            <= w_c_next;
            r_v            <= w_v_next;
            r_result       <= w_result_next;
            r_branch_valid <= branch_req;
            r_branch_taken <= branch_req && w_cond_true;
            r_illegal_cond <= branch_req && w_cond_illegal;
        end
    end

    assign w_sr_bits = {r_v, r_c, r_n, r_z};

    // SR read data: flags in the low nibble, upper bits tied to zero
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sr_rdata
        if (gi < 4) begin : g_flag
            assign sr_rdata[gi] = w_sr_bits[gi];
        end else begin : g_zero
            assign sr_rdata[gi] = 1'b0;
        end
    end

    // Upper restore bits carry no state
    if (DATA_W > 4) begin : g_wdata_upper
        logic w_unused_wdata;
        assign w_unused_wdata = ^sr_wdata[DATA_W-1:4];
    end

    assign result_q     = r_result;
    assign branch_valid = r_branch_valid;
    assign branch_taken = r_branch_taken;
    assign illegal_cond = r_illegal_cond;

    // A committed ALU function must be one of the defined operations
    a_legal_func: assert property (@(posedge clk) disable iff (rst)
        flags_update |-> w_func_legal);

endmodule

// File: tb/tb_alu_status_unit.sv
// Self-checking bench for alu_status_unit: directed scenarios followed by
// randomized traffic, all compared against a flag-level reference model.
module tb_alu_status_unit;
    import alu_status_pkg::*;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    alu_func_e         alu_func;
    logic [DATA_W-1:0] alu_result;
    logic              zero_flag;
    logic              negative_flag;
    logic              carry_flag;
    logic              signed_overflow;
    logic              flags_update;
    logic              sr_write;
    logic [DATA_W-1:0] sr_wdata;
    logic              branch_req;
    logic [3:0]        branch_cond;
    logic [DATA_W-1:0] sr_rdata;
    logic [DATA_W-1:0] result_q;
    logic              branch_valid;
    logic              branch_taken;
    logic              illegal_cond;

    alu_status_unit #(.DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_func        (alu_func),
        .alu_result      (alu_result),
        .zero_flag       (zero_flag),
        .negative_flag   (negative_flag),
        .carry_flag      (carry_flag),
        .signed_overflow (signed_overflow),
        .flags_update    (flags_update),
        .sr_write        (sr_write),
        .sr_wdata        (sr_wdata),
        .branch_req      (branch_req),
        .branch_cond     (branch_cond),
        .sr_rdata        (sr_rdata),
        .result_q        (result_q),
        .branch_valid    (branch_valid),
        .branch_taken    (branch_taken),
        .illegal_cond    (illegal_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: flags as named bits, result as an integer
    bit m_z, m_n, m_c, m_v;
    int m_res;
    bit m_valid, m_taken, m_ill;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit cond_holds(input int cc, input bit z, input bit n, input bit c, input bit v);
        case (cc)
            0:  return 1;
            1:  return z;
            2:  return !z;
            3:  return n;
            4:  return !n;
            5:  return c;
            6:  return !c;
            7:  return v;
            8:  return !v;
            9:  return n != v;           // signed less-than
            10: return n == v;           // signed greater-or-equal
            11: return c || z;           // unsigned lower-or-same
            12: return !c && !z;         // unsigned higher
            default: return 0;
        endcase
    endfunction

    // Drive the ALU side as a real ALU would for operands a, b
    task automatic set_alu(input int f, input int a, input int b);
        int r, sa, sb, sr;
        logic [2:0] f3;
        f3 = f[2:0];
        alu_func = alu_func_e'(f3);
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        carry_flag      = 1'($urandom);  // garbage for logic ops
        signed_overflow = 1'($urandom);
        case (f)
            0: begin
                r = a + b; sr = sa + sb;
                carry_flag = (r > 255);
                signed_overflow = (sr > 127) || (sr < -128);
            end
            1: begin
                r = a - b; sr = sa - sb;
                carry_flag = (a < b);
                signed_overflow = (sr > 127) || (sr < -128);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            default: r = (~a) & 255;
        endcase
        r = r & 255;
        alu_result    = r[7:0];
        zero_flag     = (r == 0);
        negative_flag = (r >= 128);
    endtask

    task automatic idle();
        flags_update = 0; sr_write = 0; branch_req = 0; branch_cond = 0;
        sr_wdata = 0; rst = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then check
    task automatic tick();
        bit nz, nn, nc, nv;
        int nres;
        bit arith;
        arith = (alu_func == ALU_ADD) || (alu_func == ALU_SUB);
        nz = m_z; nn = m_n; nc = m_c; nv = m_v; nres = m_res;
        if (sr_write) begin
            nz = sr_wdata[0]; nn = sr_wdata[1]; nc = sr_wdata[2]; nv = sr_wdata[3];
        end else if (flags_update) begin
            nz = zero_flag; nn = negative_flag;
            if (arith) begin nc = carry_flag; nv = signed_overflow; end
        end
        if (flags_update) nres = int'(alu_result);
        if (rst) begin
            m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_res = 0;
            m_valid = 0; m_taken = 0; m_ill = 0;
        end else begin
            m_z = nz; m_n = nn; m_c = nc; m_v = nv; m_res = nres;
            m_valid = branch_req;
            m_taken = branch_req && cond_holds(int'(branch_cond), nz, nn, nc, nv);
            m_ill   = branch_req && (branch_cond >= 13);
        end
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("sr_rdata@%0d", cyc), 32'(sr_rdata), 32'({m_v, m_c, m_n, m_z}));
        check($sformatf("result_q@%0d", cyc), 32'(result_q), 32'(m_res));
        check($sformatf("valid@%0d", cyc), 32'(branch_valid), 32'(m_valid));
        check($sformatf("taken@%0d", cyc), 32'(branch_taken), 32'(m_taken));
        check($sformatf("illegal@%0d", cyc), 32'(illegal_cond), 32'(m_ill));
    endtask

    initial begin
        idle();
        set_alu(0, 0, 0);
        rst = 1;
        tick(); tick();
        check("reset_sr", 32'(sr_rdata), 32'h0);
        idle();

        // Reset mid-sequence drops a pending branch
        set_alu(0, 8'h7F, 8'h01); flags_update = 1; tick();
        check("add7f_sr", 32'(sr_rdata), 32'h0A);
        idle(); rst = 1; branch_req = 1; branch_cond = 7; tick();
        check("rst_sr", 32'(sr_rdata), 32'h0);
        check("rst_res", 32'(result_q), 32'h0);
        check("rst_valid", 32'(branch_valid), 32'h0);
        idle();

        // Carry/zero, then a logic op keeps C
        set_alu(0, 8'hFF, 8'h01); flags_update = 1; tick();
        check("addff_sr", 32'(sr_rdata), 32'h05);
        set_alu(4, 8'hF0, 8'h70); tick();
        check("xor_sr", 32'(sr_rdata), 32'h06);
        check("xor_res", 32'(result_q), 32'h80);
        idle();

        // Bypass: compare and branch in the same cycle
        set_alu(1, 8'h03, 8'h05); flags_update = 1; branch_req = 1; branch_cond = 11; tick();
        check("bypass_le", 32'(branch_taken), 32'h1);
        idle(); tick();
        set_alu(1, 8'h03, 8'h05); flags_update = 1; branch_req = 1; branch_cond = 12; tick();
        check("bypass_gt", 32'(branch_taken), 32'h0);
        idle();

        // Signed compare with overflow
        set_alu(1, 8'h80, 8'h01); flags_update = 1; tick();
        idle(); branch_req = 1; branch_cond = 9; tick();
        check("signed_lt", 32'(branch_taken), 32'h1);
        branch_cond = 10; tick();
        check("signed_ge", 32'(branch_taken), 32'h0);
        idle();

        // SR restore beats the flag commit; result still latches
        set_alu(0, 8'hFF, 8'h01); flags_update = 1; sr_write = 1; sr_wdata = 8'hA8; tick();
        check("prio_sr", 32'(sr_rdata), 32'h08);
        check("prio_res", 32'(result_q), 32'h00);
        idle();

        // Back-to-back branches with Z=1
        sr_write = 1; sr_wdata = 8'h01; tick(); idle();
        branch_req = 1;
        branch_cond = 0;  tick(); check("b2b_0", 32'({branch_valid, branch_taken, illegal_cond}), 32'b110);
        branch_cond = 2;  tick(); check("b2b_2", 32'({branch_valid, branch_taken, illegal_cond}), 32'b100);
        branch_cond = 14; tick(); check("b2b_14", 32'({branch_valid, branch_taken, illegal_cond}), 32'b101);
        branch_cond = 1;  tick(); check("b2b_1", 32'({branch_valid, branch_taken, illegal_cond}), 32'b110);
        idle(); tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_alu(int'($urandom_range(0, 5)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            flags_update = ($urandom_range(0, 3) != 0);
            sr_write     = ($urandom_range(0, 7) == 0);
            sr_wdata     = 8'($urandom);
            branch_req   = ($urandom_range(0, 1) == 1);
            branch_cond  = 4'($urandom);
            rst          = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
